// File: rtl/channel_mux_array.sv
// rtl/channel_mux_array.sv - glitch-free per-channel source selector with drain/arm handover
module channel_mux_array #(
  parameter int N_CH    = 4,
  parameter int N_SRC   = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_SRC-1:0]        i_sources,
  input  logic [N_CH-1:0]         i_enable,
  input  logic [N_CH*SEL_W-1:0]   i_selector,
  input  logic                    i_update,
  output logic [N_CH-1:0]         o_channel,
  output logic [N_CH-1:0]         o_busy
);
  localparam int                 TW     = $clog2(TIMEOUT + 1);
  localparam int                 NSEL   = 1 << SEL_W;
  localparam logic [TW-1:0]      T_LAST = TW'(TIMEOUT - 1);
  // One bit per selector code: set where the code names a real source
  localparam logic [NSEL-1:0]    SEL_OK = {NSEL{1'b1}} >> (NSEL - N_SRC);

  typedef enum logic [1:0] {S_OFF, S_ARM, S_RUN, S_DRAIN} state_t;

  logic [NSEL-1:0] src_pad;

  // Widen the source bus to the full selector code space; unused codes read low
  always_comb begin
    src_pad = '0;
    src_pad[N_SRC-1:0] = i_sources;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t           state_q, state_d;
    logic             act_en_q, act_en_d, pend_en_q, pend_en_d;
    logic [SEL_W-1:0] act_sel_q, act_sel_d, pend_sel_q, pend_sel_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             out_q, out_d;
    logic [SEL_W-1:0] req_sel_raw, req_sel, cmp_sel;
    logic             req_en, cmp_en, change, cur_src, expired, busy;

    // Decode the request, detect a real change, and compute the next channel state
    always_comb begin
      req_sel_raw = i_selector[c*SEL_W +: SEL_W];
      req_en      = i_enable[c] & SEL_OK[req_sel_raw];
      req_sel     = req_en ? req_sel_raw : '0;
      busy        = (state_q == S_ARM) || (state_q == S_DRAIN);
      cmp_en      = busy ? pend_en_q  : act_en_q;
      cmp_sel     = busy ? pend_sel_q : act_sel_q;
      change      = i_update && ((req_en != cmp_en) || (req_sel != cmp_sel));
      cur_src     = src_pad[act_sel_q];
      expired     = (timer_q == T_LAST);

      state_d    = state_q;
      act_en_d   = act_en_q;
      act_sel_d  = act_sel_q;
      pend_en_d  = pend_en_q;
      pend_sel_d = pend_sel_q;
      timer_d    = timer_q;
      out_d      = 1'b0;

      case (state_q)
        S_OFF: begin
          if (change && req_en) begin
            act_en_d   = 1'b1;
            act_sel_d  = req_sel;
            pend_en_d  = 1'b1;
            pend_sel_d = req_sel;
            timer_d    = '0;
            state_d    = S_ARM;
          end
        end
        S_ARM: begin
          if (change) begin
            act_en_d   = req_en;
            act_sel_d  = req_sel;
            pend_en_d  = req_en;
            pend_sel_d = req_sel;
            timer_d    = '0;
            state_d    = req_en ? S_ARM : S_OFF;
          end else if (!cur_src || expired) begin
            timer_d = '0;
            state_d = S_RUN;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_RUN: begin
          out_d = cur_src;
          if (change) begin
            pend_en_d  = req_en;
            pend_sel_d = req_sel;
            timer_d    = '0;
            state_d    = S_DRAIN;
          end
        end
        default: begin
          // A late commit only retargets the pending config; the drain carries on
          if (change) begin
            pend_en_d  = req_en;
            pend_sel_d = req_sel;
          end
          if (!cur_src || expired) begin
            act_en_d  = pend_en_d;
            act_sel_d = pend_sel_d;
            timer_d   = '0;
            state_d   = pend_en_d ? S_ARM : S_OFF;
          end else begin
            out_d   = cur_src;
            timer_d = timer_q + TW'(1);
          end
        end
      endcase
    end

    // Channel registers; reset aborts any transition without draining
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q    <= S_OFF;
        act_en_q   <= 1'b0;
        act_sel_q  <= '0;
        pend_en_q  <= 1'b0;
        pend_sel_q <= '0;
        timer_q    <= '0;
        out_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        act_en_q   <= act_en_d;
        act_sel_q  <= act_sel_d;
        pend_en_q  <= pend_en_d;
        pend_sel_q <= pend_sel_d;
        timer_q    <= timer_d;
        out_q      <= out_d;
      end
    end

    assign o_channel[c] = out_q;
    assign o_busy[c]    = busy;
  end
endmodule

// File: tb/tb_channel_mux_array.sv
// tb/tb_channel_mux_array.sv - scoreboard bench for channel_mux_array
module tb_channel_mux_array;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sources = '0;
  logic [1:0] enable = '0;
  logic [3:0] selector = '0;
  logic       update = 1'b0;
  logic [1:0] o_channel, o_busy;

  logic [2:0] src3 = '0;
  logic       en3 = 1'b0;
  logic [1:0] sel3 = '0;
  logic       upd3 = 1'b0;
  logic       o_ch3, o_busy3;

  typedef struct {
    bit         which;
    logic [1:0] ch;
    logic [1:0] busy;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_step = 0;

  channel_mux_array #(.N_CH(2), .N_SRC(4), .SEL_W(2), .TIMEOUT(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sources(sources), .i_enable(enable),
    .i_selector(selector), .i_update(update), .o_channel(o_channel), .o_busy(o_busy)
  );

  channel_mux_array #(.N_CH(1), .N_SRC(3), .SEL_W(2), .TIMEOUT(8)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_sources(src3), .i_enable(en3),
    .i_selector(sel3), .i_update(upd3), .o_channel(o_ch3), .o_busy(o_busy3)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [3:0] src, input logic [1:0] en, input logic [3:0] sel,
                      input logic upd, input logic [1:0] ch, input logic [1:0] busy);
    @(negedge clk);
    sources = src; enable = en; selector = sel; update = upd;
    exp_q.push_back('{1'b0, ch, busy, n_step});
    n_step++;
  endtask

  task automatic step3(input logic [2:0] src, input logic en, input logic [1:0] sel,
                       input logic upd, input logic ch, input logic busy);
    @(negedge clk);
    src3 = src; en3 = en; sel3 = sel; upd3 = upd;
    exp_q.push_back('{1'b1, {1'b0, ch}, {1'b0, busy}, n_step});
    n_step++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.which) begin
          checks++;
          if (o_channel !== e.ch) begin
            errors++;
            $display("FAIL o_channel step %0d: got %b expected %b", e.id, o_channel, e.ch);
          end
          checks++;
          if (o_busy !== e.busy) begin
            errors++;
            $display("FAIL o_busy step %0d: got %b expected %b", e.id, o_busy, e.busy);
          end
        end else begin
          checks++;
          if (o_ch3 !== e.ch[0]) begin
            errors++;
            $display("FAIL o_channel3 step %0d: got %b expected %b", e.id, o_ch3, e.ch[0]);
          end
          checks++;
          if (o_busy3 !== e.busy[0]) begin
            errors++;
            $display("FAIL o_busy3 step %0d: got %b expected %b", e.id, o_busy3, e.busy[0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    // Reset: outputs clear asynchronously
    #2;
    exp_q.push_back('{1'b0, 2'b00, 2'b00, n_step}); n_step++;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Enable ch0 on src2 while src2 low: one ARM cycle, then follow
    step(4'b0000, 2'b01, 4'b0010, 1'b1, 2'b00, 2'b01);
    step(4'b0000, 2'b01, 4'b0010, 1'b0, 2'b00, 2'b00);
    step(4'b0100, 2'b01, 4'b0010, 1'b0, 2'b01, 2'b00);
    step(4'b0000, 2'b01, 4'b0010, 1'b0, 2'b00, 2'b00);
    step(4'b0100, 2'b01, 4'b0010, 1'b0, 2'b01, 2'b00);
    step(4'b0000, 2'b01, 4'b0010, 1'b0, 2'b00, 2'b00);

    // Move ch0 to src0 while src2 is low
    step(4'b0000, 2'b01, 4'b0000, 1'b1, 2'b00, 2'b01);
    step(4'b0000, 2'b01, 4'b0000, 1'b0, 2'b00, 2'b01);
    step(4'b0000, 2'b01, 4'b0000, 1'b0, 2'b00, 2'b00);

    // Glitch-free switch to src1 in the middle of a 5-cycle src0 pulse
    step(4'b0001, 2'b01, 4'b0000, 1'b0, 2'b01, 2'b00);
    step(4'b0011, 2'b01, 4'b0001, 1'b1, 2'b01, 2'b01);
    step(4'b0011, 2'b01, 4'b0001, 1'b0, 2'b01, 2'b01);
    step(4'b0011, 2'b01, 4'b0001, 1'b0, 2'b01, 2'b01);
    step(4'b0011, 2'b01, 4'b0001, 1'b0, 2'b01, 2'b01);
    step(4'b0010, 2'b01, 4'b0001, 1'b0, 2'b00, 2'b01);
    step(4'b0010, 2'b01, 4'b0001, 1'b0, 2'b00, 2'b01);
    step(4'b0000, 2'b01, 4'b0001, 1'b0, 2'b00, 2'b00);
    step(4'b0010, 2'b01, 4'b0001, 1'b0, 2'b01, 2'b00);
    step(4'b0000, 2'b01, 4'b0001, 1'b0, 2'b00, 2'b00);

    // ch1 on src3, then retarget to src0 with both sources held high: two timeouts
    step(4'b0000, 2'b11, 4'b1101, 1'b1, 2'b00, 2'b10);
    step(4'b0000, 2'b11, 4'b1101, 1'b0, 2'b00, 2'b00);
    step(4'b1000, 2'b11, 4'b1101, 1'b0, 2'b10, 2'b00);
    step(4'b1000, 2'b11, 4'b0001, 1'b1, 2'b10, 2'b10);
    for (int i = 0; i < 7; i++) step(4'b1001, 2'b11, 4'b0001, 1'b0, 2'b10, 2'b10);
    step(4'b1001, 2'b11, 4'b0001, 1'b0, 2'b00, 2'b10);
    for (int i = 0; i < 7; i++) step(4'b1001, 2'b11, 4'b0001, 1'b0, 2'b00, 2'b10);
    step(4'b1001, 2'b11, 4'b0001, 1'b0, 2'b00, 2'b00);
    step(4'b1001, 2'b11, 4'b0001, 1'b0, 2'b10, 2'b00);
    step(4'b0000, 2'b11, 4'b0001, 1'b0, 2'b00, 2'b00);

    // Disable ch0 while src1 high: drain to OFF
    step(4'b0010, 2'b11, 4'b0001, 1'b0, 2'b01, 2'b00);
    step(4'b0010, 2'b10, 4'b0001, 1'b1, 2'b01, 2'b01);
    step(4'b0010, 2'b10, 4'b0001, 1'b0, 2'b01, 2'b01);
    step(4'b0000, 2'b10, 4'b0001, 1'b0, 2'b00, 2'b00);
    step(4'b0010, 2'b10, 4'b0001, 1'b0, 2'b00, 2'b00);

    // Overlapping commits on ch0 (held strobe repeats harmlessly); ch1 untouched on src0
    step(4'b0000, 2'b11, 4'b0010, 1'b1, 2'b00, 2'b01);
    step(4'b0000, 2'b11, 4'b0010, 1'b0, 2'b00, 2'b00);
    step(4'b0101, 2'b11, 4'b0010, 1'b0, 2'b11, 2'b00);
    step(4'b0101, 2'b11, 4'b0001, 1'b1, 2'b11, 2'b01);
    step(4'b0101, 2'b11, 4'b0001, 1'b1, 2'b11, 2'b01);
    step(4'b0101, 2'b11, 4'b0011, 1'b1, 2'b11, 2'b01);
    step(4'b0001, 2'b11, 4'b0011, 1'b0, 2'b10, 2'b01);
    step(4'b1001, 2'b11, 4'b0011, 1'b0, 2'b10, 2'b01);
    step(4'b0001, 2'b11, 4'b0011, 1'b0, 2'b10, 2'b00);
    step(4'b1001, 2'b11, 4'b0011, 1'b0, 2'b11, 2'b00);
    step(4'b1000, 2'b11, 4'b0011, 1'b0, 2'b01, 2'b00);
    step(4'b0000, 2'b11, 4'b0011, 1'b0, 2'b00, 2'b00);

    // Reset in the middle of a drain
    step(4'b1000, 2'b11, 4'b0001, 1'b1, 2'b01, 2'b01);
    @(posedge clk);
    #3;
    exp_q.push_back('{1'b0, 2'b00, 2'b00, n_step}); n_step++;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    update = 1'b0;
    rst = 1'b0;
    step(4'b1111, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00);
    step(4'b0000, 2'b01, 4'b0000, 1'b1, 2'b00, 2'b01);
    step(4'b0000, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00);

    // Three-source build: selector 3 acts as a disable
    step3(3'b000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    step3(3'b000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step3(3'b001, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    step3(3'b001, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
    step3(3'b000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step3(3'b111, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step3(3'b111, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    step3(3'b111, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);

    @(negedge clk); @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/channel_mux_array.md
# channel_mux_array

Parametrised multi-channel output selector for the clock-master output stage. Routes any of `N_SRC` internal pulse sources (divided PPS, generated pulse trains, etc.) to each of `N_CH` output channels. Each channel has its own enable and selector. Configuration changes are committed by a strobe and applied glitch-free: the old source is drained to low, then the new source is armed at low, and a timeout bounds both phases. Sits between the pulse generators/dividers and the output pin drivers.

## Interface
- `N_CH`, 4, number of output channels
- `N_SRC`, 4, number of selectable sources
- `SEL_W`, 2, selector width per channel; must satisfy 2^SEL_W >= N_SRC
- `TIMEOUT`, 1024, maximum cycles a channel may spend in DRAIN or ARM; must be >= 1

Ports:
- `i_clk`  in  1  system clock; all sources are synchronous to it
- `i_rst`  in  1  asynchronous, active-high reset
- `i_sources`  in  N_SRC  source pulses; bit s is source s
- `i_enable`  in  N_CH  requested enable per channel
- `i_selector`  in  N_CH*SEL_W  requested source per channel; channel c uses bits [c*SEL_W +: SEL_W]
- `i_update`  in  1  commit strobe; captures `i_enable`/`i_selector` for all channels
- `o_channel`  out  N_CH  registered channel outputs
- `o_busy`  out  N_CH  channel is in DRAIN or ARM

## Operation
- Each channel has an active config (`en`, `sel`), a pending config, and a state in {OFF, ARM, RUN, DRAIN}.
- Commit: when `i_update`=1, a channel's requested config is a change if it differs from its pending config (in DRAIN/ARM) or its active config (OFF/RUN).
- A requested `sel` >= N_SRC is treated as `en`=0.
- OFF: `o_channel`=0. On a commit with `en`=1: load `sel`, reset the timer, go to ARM. On a commit with `en`=0: stay in OFF.
- ARM: `o_channel`=0. At an edge where `i_sources[sel]`=0 is sampled, go to RUN. If the timer reaches TIMEOUT-1 with the source still high, go to RUN anyway. A commit in ARM behaves as follows:
  - new `en`=1: replace `sel` and restart the timer.
  - new `en`=0: go to OFF.
- RUN: `o_channel` <= `i_sources[sel]` every edge. A commit with a change stores the pending config and goes to DRAIN with the timer reset. A commit with no change is ignored.
- DRAIN: `o_channel` keeps following the old source. At an edge where the old source is sampled 0, or where the timer reaches TIMEOUT-1, the channel does all of the following at that edge:
  - drives `o_channel` <= 0;
  - copies pending into active;
  - goes to ARM (timer reset) if `en`=1, else to OFF.
- A commit in DRAIN only overwrites pending; draining of the old source continues.
- The timer is per channel, counts edges spent in DRAIN/ARM, and is cleared on every state entry. Width is the ceiling of log2(TIMEOUT+1).
- Channels are fully independent. One `i_update` may start different transitions on different channels.

## Timing
- Reset (async assert, sampled release): `o_channel`=0, `o_busy`=0, all states OFF, active/pending `en`=0 and `sel`=0, timers 0.
- RUN latency: source to `o_channel` is 1 cycle.
- `i_update` sampled at edge k: the state change is visible after edge k, and `o_busy` rises the cycle after edge k.
- ARM exit at edge k: the first followed source value appears on `o_channel` after edge k+1.
- Maximum switch time for one commit is 2*TIMEOUT+1 cycles.
- When forced, `o_channel` drops to 0 for at least 1 cycle between old and new sources. A truncated high pulse is only possible on timeout.
- `i_update` held high for several cycles is treated as repeated commits of the same request, which has no further effect after the first.
- Reset mid-transition aborts it immediately, with no drain.

## Test plan
- Use N_CH=2, N_SRC=4, SEL_W=2, TIMEOUT=8 for all scenarios.
- Reset and enable: after reset, `o_channel`=00. Commit ch0 `en`=1, `sel`=2 with src2 low. ARM lasts 1 cycle, then `o_channel[0]` follows src2 with 1-cycle latency, and `o_busy[0]` pulses for 1 cycle.
- Glitch-free switch: ch0 on src0, which is high for 5 cycles. Commit `sel`=1 mid-pulse (src1 high) → `o_channel[0]` completes the full src0 pulse, goes 0, waits for src1 low, then follows src1. There is no partial src1 pulse.
- Timeouts: ch1 in RUN on src3 held high. Commit `sel`=0 → DRAIN times out after 8 cycles and `o_channel[1]` goes 0. Then src0 held high → ARM times out after 8 more cycles and the channel enters RUN.
- Disable and invalid selector: commit ch0 `en`=0 while src high → drain, then OFF with `o_channel[0]`=0. Separately, a `sel` value >= N_SRC (only possible with a non-power-of-two N_SRC build, e.g. N_SRC=3, `sel`=3) → channel goes to OFF and stays 0.
- Overlapping commits and independence: commit ch0 `sel`=1 during DRAIN, then commit `sel`=3 before the drain ends → the channel ends in RUN on src3. Ch1 meanwhile stays untouched in RUN.
- Reset mid-DRAIN: assert `i_rst` asynchronously → `o_channel` and `o_busy` are 0 immediately, and the channel is in OFF after release.
